// File: rtl/psum_accum_drain_pkg.sv
// Shared types and helpers for the psum accumulate/ReLU drain block.
package psum_accum_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Bit offset of lane 'lane' inside a packed vector of 'bw'-wide lanes.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/psum_lane_relu.sv
// Combinational ReLU for one signed psum lane.
module psum_lane_relu #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout
);

  function automatic logic [psum_bw-1:0] relu(input logic signed [psum_bw-1:0] x);
    return x[psum_bw-1] ? '0 : x;
  endfunction

  assign dout = relu(din);

endmodule

// File: rtl/psum_accum_drain.sv
// Pops psum vectors from the OFIFO, accumulates them per output pixel over
// the kernel taps, then streams the ReLU'd bank into the psum memory.
module psum_accum_drain
  import psum_accum_drain_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int len_onij = 16,
  parameter int len_kij  = 9,
  parameter int addr_bw  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   pmem_wr,
  output logic [addr_bw-1:0]     pmem_addr,
  output logic [psum_bw*col-1:0] pmem_data,
  output logic                   busy,
  output logic                   done
);

  localparam int KIJ_W = (len_kij > 1) ? $clog2(len_kij) : 1;
  localparam logic [addr_bw-1:0] ONIJ_LAST = addr_bw'(len_onij - 1);
  localparam logic [KIJ_W-1:0]   KIJ_LAST  = KIJ_W'(len_kij - 1);

  // Two's-complement add at lane width; overflow wraps by truncation.
  function automatic logic signed [psum_bw-1:0] wrap_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    return a + b;
  endfunction

  state_t               state, state_n;
  logic [addr_bw-1:0]   onij_cnt;
  logic [KIJ_W-1:0]     kij_cnt;
  logic                 mode_q;
  logic                 onij_last;
  logic                 kij_last;
  logic                 pop;
  logic                 wr_req;

  logic signed [psum_bw-1:0] acc     [len_onij][col];
  logic signed [psum_bw-1:0] in_lane [col];
  logic [psum_bw-1:0]        rd_lane [col];
  logic [psum_bw*col-1:0]    relu_vec;

  logic                      vld_p1;
  logic [addr_bw-1:0]        addr_p1;
  logic [psum_bw*col-1:0]    data_p1;

  assign onij_last = (onij_cnt == ONIJ_LAST);
  assign kij_last  = (mode_q == MODE_OS) ? (kij_cnt == '0) : (kij_cnt == KIJ_LAST);
  assign pop       = (state == ST_DRAIN) && ofifo_valid;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Unpack the show-ahead OFIFO head into signed lanes.
  for (genvar i = 0; i < col; i++) begin : g_in
    assign in_lane[i] = ofifo_out[lane_lsb(i, psum_bw) +: psum_bw];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and combinational control; FLUSH lingers one extra cycle so
  // DONE lands on the cycle after the last visible write.
  always_comb begin
    state_n  = state;
    ofifo_rd = 1'b0;
    wr_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        ofifo_rd = ofifo_valid;
        if (ofifo_valid && onij_last && kij_last) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (vld_p1 && (addr_p1 == ONIJ_LAST)) state_n = ST_DONE;
        else                                   wr_req  = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pixel/tap counters and the per-tile mode latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      onij_cnt <= '0;
      kij_cnt  <= '0;
      mode_q   <= MODE_WS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            onij_cnt <= '0;
            kij_cnt  <= '0;
            mode_q   <= mode;
          end
        end
        ST_DRAIN: begin
          if (ofifo_valid) begin
            if (onij_last) begin
              onij_cnt <= '0;
              kij_cnt  <= kij_last ? '0 : kij_cnt + 1'b1;
            end else begin
              onij_cnt <= onij_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (wr_req) onij_cnt <= onij_last ? '0 : onij_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Accumulator read-modify-write. The bank is read combinationally, so a
  // write on one edge is already visible to the read in the next cycle,
  // which covers back-to-back hits on the same pixel (len_onij == 1).
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < col; i++) begin
        acc[onij_cnt][i] <= wrap_add((kij_cnt == '0) ? '0 : acc[onij_cnt][i], in_lane[i]);
      end
    end
  end

  // Flush read path: current pixel through per-lane ReLU.
  for (genvar i = 0; i < col; i++) begin : g_relu
    assign rd_lane[i] = acc[onij_cnt][i];
    psum_lane_relu #(.psum_bw(psum_bw)) u_relu (
      .din  (rd_lane[i]),
      .dout (relu_vec[lane_lsb(i, psum_bw) +: psum_bw])
    );
  end

  // ---- stage p0 -> p1: registered psum memory write ----
  // Outputs are cleared on reset so an abandoned tile cannot write.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_req;
      if (wr_req) begin
        addr_p1 <= onij_cnt;
        data_p1 <= relu_vec;
      end
    end
  end

  assign pmem_wr   = vld_p1;
  assign pmem_addr = addr_p1;
  assign pmem_data = data_p1;

endmodule

// File: doc/psum_accum_drain.md
Name: psum_accum_drain

Overview:
- Downstream consumer of the corelet's OFIFO output.
- Pops one psum vector per output pixel (onij) for each kernel tap (kij) and accumulates per lane into an internal bank.
- After the last tap, applies ReLU and streams the results to the psum memory, one address per cycle.
- Implements the weight-stationary accumulate/ReLU pass in hardware instead of the testbench; in output-stationary mode it performs a single pass (ReLU and write only).

Parameters:
- psum_bw, 16, width of one psum lane (signed).
- col, 8, number of lanes per vector.
- len_onij, 16, output pixels per tile (accumulator depth).
- len_kij, 9, kernel taps accumulated per pixel in WS mode.
- addr_bw, 4, pmem address width; must satisfy 2^addr_bw >= len_onij.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a tile; ignored unless in IDLE.
- mode  input  1  0 = WS (accumulate len_kij passes), 1 = OS (single pass).
- ofifo_valid  input  1  OFIFO holds a full vector; data is show-ahead.
- ofifo_out  input  psum_bw*col  head vector from OFIFO; lane i is bits [(i+1)*psum_bw-1 : i*psum_bw].
- ofifo_rd  output  1  pop strobe to OFIFO.
- pmem_wr  output  1  psum memory write enable.
- pmem_addr  output  addr_bw  psum memory write address.
- pmem_data  output  psum_bw*col  post-ReLU vector.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at tile completion.

Behaviour:
- States: IDLE, DRAIN, FLUSH, DONE. Counters: onij_cnt (0..len_onij-1), kij_cnt (0..len_kij-1).
- Effective pass count: passes = mode ? 1 : len_kij. Mode is sampled on start and held for the whole tile.
- IDLE -> DRAIN when start=1. Both counters clear on this transition.
- DRAIN:
  - ofifo_rd = ofifo_valid (combinational, asserted only in DRAIN).
  - On each pop: acc[onij_cnt][i] <= (kij_cnt==0 ? 0 : acc[onij_cnt][i]) + ofifo_out lane i.
  - Addition is signed two's-complement at psum_bw bits; overflow wraps with no saturation.
  - onij_cnt increments per pop and wraps to 0 after len_onij-1; kij_cnt increments on that wrap.
  - No pop means no state change (stall indefinitely).
- DRAIN -> FLUSH on the pop where onij_cnt==len_onij-1 and kij_cnt==passes-1. onij_cnt clears.
- FLUSH:
  - Outputs are registered. In the cycle after each FLUSH cycle k: pmem_wr=1, pmem_addr=k, pmem_data lane i = (acc[k][i] < 0) ? 0 : acc[k][i].
  - Exactly len_onij consecutive write cycles; ofifo_rd=0 throughout.
  - -> DONE after the cycle issuing address len_onij-1.
- DONE: done=1 for one cycle, coinciding with the cycle after the last pmem_wr=1 cycle. Then -> IDLE.
- Reset values: state IDLE, both counters 0; ofifo_rd, pmem_wr, done, busy = 0; pmem_addr = 0; pmem_data = 0. Accumulator contents are not reset (kij==0 overwrites them).
- Reset mid-tile returns to IDLE on the next edge. Any partially accumulated tile is abandoned, and no further pmem writes occur.
- start while busy is ignored and has no effect on counters.
- Simultaneous reset and start: reset wins.
- Accumulator storage is a register array len_onij x col x psum_bw with one read-modify-write per cycle and no hazard, because the same onij is never popped on consecutive cycles unless len_onij=1. The len_onij=1 case must still be correct: a read in the same cycle as a write sees the just-written value via a bypass.

Decomposition:
- Shared package: state encoding (IDLE/DRAIN/FLUSH/DONE), mode encodings (MODE_WS=0, MODE_OS=1), and a lane-slice helper function.
- One natural sub-module: psum_lane_relu (combinational per-lane ReLU, psum_bw wide), instantiated col times in a generate loop.

Test Plan:
- WS, len_kij=9, len_onij=16, every popped lane = +1, ofifo_valid always high -> 144 pops; then pmem_wr for 16 consecutive cycles at addr 0..15 with every lane = 9; done pulses the cycle after addr 15; busy=1 from the cycle after start until the cycle after done.
- WS, lane 0 = -3 per tap, lane 1 = +2 per tap -> every address writes lane0 = 0 (ReLU of -27) and lane1 = 18.
- OS, start with mode=1, 16 pops of lane value 0x7FFF -> 16 writes of 0x7FFF; no second pass.
- Wrap: 9 taps of 0x4000 per lane -> sum 0x24000 truncates to 0x4000 (positive), so 0x4000 is written.
- ofifo_valid toggled randomly at 30% -> ofifo_rd only when valid; final results identical to scenario 1.
- Reset asserted mid-DRAIN at pop 50, then start again -> no pmem_wr before the new tile's flush; the new tile with lane value 2 yields 18 at every address. Also: start pulsed during FLUSH is ignored.
